// File: rtl/ram16k_arbiter_if.sv
// Bus bundle for the RAM16K arbiter: two requester ports plus the RAM port.
// The slave view belongs to the arbiter; the master view belongs to the
// requesters and the RAM instance that sit around it.
interface ram16k_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              ram_e;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_w;
    logic              ram_r;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_e, ram_addr, ram_din, ram_w, ram_r,
        output ram_dout
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_e, ram_addr, ram_din, ram_w, ram_r,
        input  ram_dout
    );
endinterface

// File: rtl/ram16k_arbiter.sv
// Two-port arbiter and sequencer for the 16K x 16 main memory.
// Port A (instruction fetch) and port B (data) share one RAM port. A request
// is accepted in IDLE, replayed to the RAM during one ACCESS cycle, and a read
// returns registered data with a one-cycle rvalid pulse on the following cycle.
module ram16k_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input logic             clk,
    input logic             re,
    ram16k_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    state_t            state;
    state_t            state_next;
    port_t             owner;
    port_t             prio;

    // Request captured at the accept edge, replayed during ACCESS
    logic [ADDR_W-1:0] req_addr_p1;
    logic              req_we_p1;
    logic [DATA_W-1:0] req_wdata_p1;

    // Read return, presented the cycle after ACCESS
    logic              a_rvalid_p2;
    logic              b_rvalid_p2;
    logic [DATA_W-1:0] a_rdata_p2;
    logic [DATA_W-1:0] b_rdata_p2;

    logic              a_gnt;
    logic              b_gnt;
    logic              ram_e;
    logic              ram_w;
    logic              ram_r;

    // State register; reset always lands in IDLE, aborting any ACCESS
    always_ff @(posedge clk) begin
        if (!re) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, next state and RAM strobes; reset masks every strobe
    always_comb begin
        state_next = state;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        ram_e      = 1'b0;
        ram_w      = 1'b0;
        ram_r      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.a_req && (!bus.b_req || prio == PORT_A)) begin
                    a_gnt = 1'b1;
                end else if (bus.b_req) begin
                    b_gnt = 1'b1;
                end
                if (a_gnt || b_gnt) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                ram_e      = 1'b1;
                ram_w      = req_we_p1;
                ram_r      = !req_we_p1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (!re) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
            ram_e = 1'b0;
            ram_w = 1'b0;
            ram_r = 1'b0;
        end
    end

    // Latch the granted request and hand priority to the other port
    always_ff @(posedge clk) begin
        if (!re) begin
            owner        <= PORT_A;
            prio         <= PORT_A;
            req_addr_p1  <= '0;
            req_we_p1    <= 1'b0;
            req_wdata_p1 <= '0;
        end else if (a_gnt) begin
            owner        <= PORT_A;
            prio         <= PORT_B;
            req_addr_p1  <= bus.a_addr;
            req_we_p1    <= bus.a_we;
            req_wdata_p1 <= bus.a_wdata;
        end else if (b_gnt) begin
            owner        <= PORT_B;
            prio         <= PORT_A;
            req_addr_p1  <= bus.b_addr;
            req_we_p1    <= bus.b_we;
            req_wdata_p1 <= bus.b_wdata;
        end
    end

    // ---- stage boundary: ACCESS -> read return ----
    // Capture RAM read data for the owner at the edge ending ACCESS
    always_ff @(posedge clk) begin
        if (!re) begin
            a_rvalid_p2 <= 1'b0;
            b_rvalid_p2 <= 1'b0;
            a_rdata_p2  <= '0;
            b_rdata_p2  <= '0;
        end else begin
            a_rvalid_p2 <= 1'b0;
            b_rvalid_p2 <= 1'b0;
            if (state == ACCESS && !req_we_p1) begin
                if (owner == PORT_A) begin
                    a_rdata_p2  <= bus.ram_dout;
                    a_rvalid_p2 <= 1'b1;
                end else begin
                    b_rdata_p2  <= bus.ram_dout;
                    b_rvalid_p2 <= 1'b1;
                end
            end
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = a_rvalid_p2;
    assign bus.b_rvalid = b_rvalid_p2;
    assign bus.a_rdata  = a_rdata_p2;
    assign bus.b_rdata  = b_rdata_p2;
    assign bus.ram_e    = ram_e;
    assign bus.ram_w    = ram_w;
    assign bus.ram_r    = ram_r;
    assign bus.ram_addr = req_addr_p1;
    assign bus.ram_din  = req_wdata_p1;

endmodule
